// File: rtl/jtvigil_scrregs.sv
// Main CPU video control ports: scroll, rear-layer colour/enable, flip and sound latch.
// Scroll and colour values are written to shadow registers and copied to the outputs at vertical blank.
module jtvigil_scrregs #(
    parameter bit LATCH_VB = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_cen,
    input  logic        io_cs,
    input  logic        rnw,
    input  logic [2:0]  addr,
    input  logic [7:0]  din,
    input  logic        LVBL,
    output logic [8:0]  scr1pos,
    output logic [10:0] scr2pos,
    output logic [2:0]  scr2col,
    output logic        scr2enb,
    output logic        flip,
    output logic        latch_wr,
    output logic [7:0]  snd_latch,
    output logic        pend
);

    logic [8:0]  sh_scr1pos;
    logic [10:0] sh_scr2pos;
    logic [2:0]  sh_scr2col;
    logic        sh_scr2enb;
    logic        lvbl_l;
    logic        done;
    logic        wr_ok;
    logic        xfer;

    // done blocks further updates until io_cs drops, so a long access counts once
    assign wr_ok = io_cs & ~rnw & cpu_cen & ~done;
    assign xfer  = LATCH_VB ? (lvbl_l & ~LVBL) : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_scr1pos <= '0;
            sh_scr2pos <= '0;
            sh_scr2col <= '0;
            sh_scr2enb <= 1'b1;
            scr1pos    <= '0;
            scr2pos    <= '0;
            scr2col    <= '0;
            scr2enb    <= 1'b1;
            flip       <= 1'b0;
            latch_wr   <= 1'b0;
            snd_latch  <= '0;
            pend       <= 1'b0;
            lvbl_l     <= 1'b1;
            done       <= 1'b0;
        end else begin
            lvbl_l <= LVBL;

            if (!io_cs)
                done <= 1'b0;
            else if (wr_ok)
                done <= 1'b1;

            latch_wr <= wr_ok && (addr == 3'd6) && !latch_wr;

            if (wr_ok) begin
                case (addr)
                    3'd0: sh_scr1pos[7:0]  <= din;
                    3'd1: sh_scr1pos[8]    <= din[0];
                    3'd2: sh_scr2pos[7:0]  <= din;
                    3'd3: sh_scr2pos[10:8] <= din[2:0];
                    3'd4: begin
                        sh_scr2col <= din[2:0];
                        sh_scr2enb <= ~din[6];
                    end
                    3'd5: flip      <= din[0];
                    3'd6: snd_latch <= din;
                    default: ;
                endcase
            end

            // Nonblocking reads here see the shadow values from before any same-cycle write
            if (xfer) begin
                scr1pos <= sh_scr1pos;
                scr2pos <= sh_scr2pos;
                scr2col <= sh_scr2col;
                scr2enb <= sh_scr2enb;
            end

            if (wr_ok && (addr <= 3'd4))
                pend <= 1'b1;
            else if (xfer)
                pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtvigil_scrregs.sv
// Directed bench for jtvigil_scrregs: vector table plus hand sequences for latch, reset and unbuffered mode.
module tb_jtvigil_scrregs;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_cen, io_cs, rnw, lvbl;
    logic [2:0]  addr;
    logic [7:0]  din;
    logic [8:0]  scr1pos;
    logic [10:0] scr2pos;
    logic [2:0]  scr2col;
    logic        scr2enb, flip, latch_wr, pend;
    logic [7:0]  snd_latch;

    logic        cpu_cen1, io_cs1, rnw1, lvbl1;
    logic [2:0]  addr1;
    logic [7:0]  din1;
    logic [8:0]  scr1pos1;
    logic [10:0] scr2pos1;
    logic [2:0]  scr2col1;
    logic        scr2enb1, flip1, latch_wr1, pend1;
    logic [7:0]  snd_latch1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtvigil_scrregs #(.LATCH_VB(1'b1)) u_dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .io_cs(io_cs), .rnw(rnw),
        .addr(addr), .din(din), .LVBL(lvbl),
        .scr1pos(scr1pos), .scr2pos(scr2pos), .scr2col(scr2col), .scr2enb(scr2enb),
        .flip(flip), .latch_wr(latch_wr), .snd_latch(snd_latch), .pend(pend)
    );

    jtvigil_scrregs #(.LATCH_VB(1'b0)) u_dut_nvb (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen1), .io_cs(io_cs1), .rnw(rnw1),
        .addr(addr1), .din(din1), .LVBL(lvbl1),
        .scr1pos(scr1pos1), .scr2pos(scr2pos1), .scr2col(scr2col1), .scr2enb(scr2enb1),
        .flip(flip1), .latch_wr(latch_wr1), .snd_latch(snd_latch1), .pend(pend1)
    );

    typedef struct {
        logic        io;
        logic        rd;
        logic [2:0]  a;
        logic [7:0]  d;
        logic        vb;
        logic [8:0]  s1;
        logic [10:0] s2;
        logic [2:0]  col;
        logic        enb;
        logic        flp;
        logic        pnd;
    } vec_t;

    vec_t tbl[28];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {scr1pos, scr2pos, scr2col, scr2enb, flip, latch_wr, snd_latch, pend}
    function automatic logic [63:0] pack(logic [8:0] s1, logic [10:0] s2, logic [2:0] c,
                                         logic e, logic f, logic lw, logic [7:0] sl, logic p);
        return {29'd0, s1, s2, c, e, f, lw, sl, p};
    endfunction

    function automatic logic [63:0] dut_state();
        return pack(scr1pos, scr2pos, scr2col, scr2enb, flip, latch_wr, snd_latch, pend);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ones;
        logic prev_lw;

        // io, rd, addr, din, LVBL -> scr1pos, scr2pos, scr2col, scr2enb, flip, pend
        tbl[0]  = '{1'b1, 1'b0, 3'd2, 8'h34, 1'b1, 9'h000, 11'h000, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h000, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 3'd3, 8'hFD, 1'b1, 9'h000, 11'h000, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h000, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 9'h000, 11'h534, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 9'h000, 11'h534, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd4, 8'h47, 1'b0, 9'h000, 11'h534, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 9'h000, 11'h534, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h534, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 9'h000, 11'h534, 3'd7, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h534, 3'd7, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'd4, 8'h03, 1'b1, 9'h000, 11'h534, 3'd7, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h534, 3'd7, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 9'h000, 11'h534, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h534, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 3'd5, 8'h01, 1'b1, 9'h000, 11'h534, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 3'd5, 8'h00, 1'b1, 9'h000, 11'h534, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h534, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 3'd7, 8'hFF, 1'b1, 9'h000, 11'h534, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h534, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 3'd0, 8'hFF, 1'b0, 9'h000, 11'h534, 3'd3, 1'b1, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 9'h000, 11'h534, 3'd3, 1'b1, 1'b1, 1'b1};
        tbl[22] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h000, 11'h534, 3'd3, 1'b1, 1'b1, 1'b1};
        tbl[23] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 9'h0FF, 11'h534, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[24] = '{1'b1, 1'b0, 3'd1, 8'h03, 1'b1, 9'h0FF, 11'h534, 3'd3, 1'b1, 1'b1, 1'b1};
        tbl[25] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h0FF, 11'h534, 3'd3, 1'b1, 1'b1, 1'b1};
        tbl[26] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 9'h1FF, 11'h534, 3'd3, 1'b1, 1'b1, 1'b0};
        tbl[27] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 9'h1FF, 11'h534, 3'd3, 1'b1, 1'b1, 1'b0};

        rst = 1'b0;
        cpu_cen = 1'b1; io_cs = 1'b0; rnw = 1'b1; addr = '0; din = '0; lvbl = 1'b1;
        cpu_cen1 = 1'b1; io_cs1 = 1'b0; rnw1 = 1'b1; addr1 = '0; din1 = '0; lvbl1 = 1'b1;
        repeat (3) tick();
        check("reset_state", dut_state(), pack(9'h0, 11'h0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
        rst = 1'b1;
        tick();
        check("after_release", dut_state(), pack(9'h0, 11'h0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));

        for (int i = 0; i < 28; i++) begin
            io_cs = tbl[i].io; rnw = tbl[i].rd; addr = tbl[i].a; din = tbl[i].d; lvbl = tbl[i].vb;
            tick();
            check($sformatf("vec%0d", i), dut_state(),
                  pack(tbl[i].s1, tbl[i].s2, tbl[i].col, tbl[i].enb, tbl[i].flp, 1'b0, 8'h00, tbl[i].pnd));
        end
        io_cs = 1'b0; rnw = 1'b1; lvbl = 1'b1;

        // Port 6 held over four cen pulses: a single strobe
        ones = 0; prev_lw = 1'b0;
        io_cs = 1'b1; rnw = 1'b0; addr = 3'd6; din = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            cpu_cen = (k % 2 == 0);
            tick();
            if (latch_wr) ones++;
            if (latch_wr && prev_lw) check("lw_consecutive", 64'd1, 64'd0);
            prev_lw = latch_wr;
        end
        cpu_cen = 1'b1; io_cs = 1'b0;
        tick();
        if (latch_wr) ones++;
        check("lw_pulse_count", 64'(ones), 64'd1);
        check("snd_latch_a5", 64'(snd_latch), 64'hA5);

        // Back-to-back accesses separated by one idle cycle
        ones = 0; prev_lw = latch_wr;
        io_cs = 1'b1; rnw = 1'b0; addr = 3'd6; din = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            io_cs = (k != 1);
            tick();
            if (latch_wr) ones++;
            if (latch_wr && prev_lw) check("lw_back2back_consec", 64'd1, 64'd0);
            prev_lw = latch_wr;
        end
        io_cs = 1'b0;
        tick();
        if (latch_wr) ones++;
        check("lw_back2back_count", 64'(ones), 64'd2);
        check("snd_latch_5a", 64'(snd_latch), 64'h5A);
        check("lw_no_pend", 64'(pend), 64'd0);

        // Pending write discarded by reset; first edge afterwards transfers zeros
        io_cs = 1'b1; rnw = 1'b0; addr = 3'd0; din = 8'hFF; lvbl = 1'b1;
        tick();
        io_cs = 1'b0;
        tick();
        check("pre_reset_pend", 64'(pend), 64'd1);
        rst = 1'b0;
        #2;
        check("midframe_reset", dut_state(), pack(9'h0, 11'h0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
        tick();
        rst = 1'b1;
        tick();
        lvbl = 1'b0;
        tick();
        check("edge_after_reset", dut_state(), pack(9'h0, 11'h0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0));
        lvbl = 1'b1;
        tick();

        // Unbuffered instance: outputs follow one clk after the write
        io_cs1 = 1'b1; rnw1 = 1'b0; addr1 = 3'd0; din1 = 8'h12;
        tick();
        io_cs1 = 1'b0; rnw1 = 1'b1;
        check("nvb_write_edge_scr1", 64'(scr1pos1), 64'h000);
        check("nvb_write_edge_pend", 64'(pend1), 64'd1);
        tick();
        check("nvb_follow_scr1", 64'(scr1pos1), 64'h012);
        check("nvb_follow_pend", 64'(pend1), 64'd0);
        io_cs1 = 1'b1; rnw1 = 1'b0; addr1 = 3'd4; din1 = 8'h45;
        tick();
        io_cs1 = 1'b0; rnw1 = 1'b1;
        tick();
        check("nvb_col_enb", 64'({scr2col1, scr2enb1}), 64'({3'd5, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
